// File: rtl/work_loader.sv
// work_loader: frames and checksums 80-byte mining jobs from the UART byte
// stream, holds the last good job on its outputs and replies ACK/NAK.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   rx_data, rx_valid           received byte stream (no backpressure)
//   tx_data, tx_valid, tx_ready reply byte handshake (0x06 ACK, 0x15 NAK)
//   digest_initial .. nonce     job fields, updated only on an accepted frame
//   write_en                    one-cycle pulse when the job fields change
//   frame_err                   one-cycle pulse on checksum mismatch or timeout
//   busy                        high whenever a frame or reply is in progress
//   good_cnt                    accepted-job counter, wraps 255 to 0
module work_loader #(
    parameter int TIMEOUT_CYCLES = 100_000_000,
    parameter int TO_W           = 27
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [7:0]   rx_data,
    input  logic         rx_valid,
    output logic [7:0]   tx_data,
    output logic         tx_valid,
    input  logic         tx_ready,
    output logic [255:0] digest_initial,
    output logic [255:0] digest,
    output logic [31:0]  merkle,
    output logic [31:0]  time_out,
    output logic [31:0]  target,
    output logic [31:0]  nonce,
    output logic         write_en,
    output logic         frame_err,
    output logic         busy,
    output logic [7:0]   good_cnt
);

    localparam logic [1:0] S_HUNT  = 2'd0;
    localparam logic [1:0] S_PAY   = 2'd1;
    localparam logic [1:0] S_CHK   = 2'd2;
    localparam logic [1:0] S_REPLY = 2'd3;

    localparam logic [7:0] SYNC = 8'hA5;
    localparam logic [7:0] ACK  = 8'h06;
    localparam logic [7:0] NAK  = 8'h15;

    localparam logic [6:0] LAST_IDX = 7'd79;

    // The idle count seen in the cycle before the edge that reaches the limit.
    localparam logic [TO_W-1:0] IDLE_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TO_W-1:0] IDLE_ONE  = TO_W'(1);

    logic [1:0]      state;
    logic [6:0]      cnt;
    logic [7:0]      acc;
    logic [639:0]    sr;
    logic [TO_W-1:0] idle;
    logic            timeout;

    assign busy = (state != S_HUNT);

    // The timeout wins even if a byte arrives on the same edge.
    assign timeout = ((state == S_PAY) || (state == S_CHK)) &&
                     (idle == IDLE_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_HUNT;
            cnt            <= '0;
            acc            <= '0;
            sr             <= '0;
            idle           <= '0;
            tx_data        <= '0;
            tx_valid       <= 1'b0;
            digest_initial <= '0;
            digest         <= '0;
            merkle         <= '0;
            time_out       <= '0;
            target         <= '0;
            nonce          <= '0;
            write_en       <= 1'b0;
            frame_err      <= 1'b0;
            good_cnt       <= '0;
        end else begin
            write_en  <= 1'b0;
            frame_err <= 1'b0;
            if (timeout) begin
                frame_err <= 1'b1;
                idle      <= '0;
                state     <= S_HUNT;
            end else begin
                unique case (state)
                    S_HUNT: begin
                        if (rx_valid && (rx_data == SYNC)) begin
                            cnt   <= '0;
                            acc   <= '0;
                            idle  <= '0;
                            state <= S_PAY;
                        end
                    end
                    S_PAY: begin
                        if (rx_valid) begin
                            sr   <= {sr[631:0], rx_data};
                            acc  <= acc ^ rx_data;
                            cnt  <= cnt + 7'd1;
                            idle <= '0;
                            if (cnt == LAST_IDX) begin
                                state <= S_CHK;
                            end
                        end else begin
                            idle <= idle + IDLE_ONE;
                        end
                    end
                    S_CHK: begin
                        if (rx_valid) begin
                            idle     <= '0;
                            tx_valid <= 1'b1;
                            state    <= S_REPLY;
                            if (rx_data == acc) begin
                                // First payload byte sits at the top of sr.
                                digest_initial <= sr[639:384];
                                digest         <= sr[383:128];
                                merkle         <= sr[127:96];
                                time_out       <= sr[95:64];
                                target         <= sr[63:32];
                                nonce          <= sr[31:0];
                                write_en       <= 1'b1;
                                good_cnt       <= good_cnt + 8'd1;
                                tx_data        <= ACK;
                            end else begin
                                frame_err <= 1'b1;
                                tx_data   <= NAK;
                            end
                        end else begin
                            idle <= idle + IDLE_ONE;
                        end
                    end
                    S_REPLY: begin
                        // Incoming bytes are dropped until the reply is taken.
                        if (tx_ready) begin
                            tx_valid <= 1'b0;
                            state    <= S_HUNT;
                        end
                    end
                    default: begin
                        state <= S_HUNT;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_work_loader.sv
// tb_work_loader: scoreboard bench for work_loader with a field-level model.
// Stimulus pushes expected jobs/replies/errors; a monitor pops and compares.
module tb_work_loader;

    localparam int TO = 50;

    typedef struct packed {
        logic [255:0] di;
        logic [255:0] dg;
        logic [31:0]  mk;
        logic [31:0]  tm;
        logic [31:0]  tg;
        logic [31:0]  nc;
        logic [7:0]   cnt;
    } job_t;

    logic         clk;
    logic         rst_n;
    logic [7:0]   rx_data;
    logic         rx_valid;
    logic [7:0]   tx_data;
    logic         tx_valid;
    logic         tx_ready;
    logic [255:0] digest_initial;
    logic [255:0] digest;
    logic [31:0]  merkle;
    logic [31:0]  time_out;
    logic [31:0]  target;
    logic [31:0]  nonce;
    logic         write_en;
    logic         frame_err;
    logic         busy;
    logic [7:0]   good_cnt;

    work_loader #(.TIMEOUT_CYCLES(TO), .TO_W(6)) dut (
        .clk(clk), .rst_n(rst_n),
        .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .digest_initial(digest_initial), .digest(digest),
        .merkle(merkle), .time_out(time_out),
        .target(target), .nonce(nonce),
        .write_en(write_en), .frame_err(frame_err),
        .busy(busy), .good_cnt(good_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_fail = 0;

    job_t       exp_job[$];
    logic [7:0] exp_tx[$];
    job_t       exp_ej[$];
    int         exp_ec[$];

    job_t       last_good;
    logic [7:0] model_cnt;
    logic [7:0] fb[80];
    int         last_t;
    bit         rand_rdy;

    task automatic chk(input string nm, input logic [255:0] act,
                       input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_job(input string nm, input job_t j);
        chk({nm, ".di"}, digest_initial, j.di);
        chk({nm, ".dg"}, digest, j.dg);
        chk({nm, ".mk"}, {224'd0, merkle}, {224'd0, j.mk});
        chk({nm, ".tm"}, {224'd0, time_out}, {224'd0, j.tm});
        chk({nm, ".tg"}, {224'd0, target}, {224'd0, j.tg});
        chk({nm, ".nc"}, {224'd0, nonce}, {224'd0, j.nc});
        chk({nm, ".cnt"}, {248'd0, good_cnt}, {248'd0, j.cnt});
    endtask

    // Monitor: sampled on the falling edge, away from the active edge.
    logic       prev_v = 1'b0;
    logic       prev_hs = 1'b0;
    logic [7:0] prev_d = 8'h00;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_v  <= 1'b0;
            prev_hs <= 1'b0;
        end else begin
            if (write_en) begin
                if (exp_job.size() == 0) begin
                    chk("unexpected_write_en", 1, 0);
                end else begin
                    chk_job("job", exp_job.pop_front());
                end
            end
            if (frame_err) begin
                if (exp_ej.size() == 0) begin
                    chk("unexpected_frame_err", 1, 0);
                end else begin
                    int c;
                    chk_job("err_hold", exp_ej.pop_front());
                    c = exp_ec.pop_front();
                    if (c >= 0) chk("timeout_cycle", cyc, c);
                end
            end
            if (prev_v && !prev_hs) begin
                chk("tx_valid_hold", tx_valid, 1);
                chk("tx_data_hold", tx_data, prev_d);
            end
            if (tx_valid && tx_ready) begin
                if (exp_tx.size() == 0) begin
                    chk("unexpected_reply", 1, 0);
                end else begin
                    chk("reply_byte", tx_data, exp_tx.pop_front());
                end
            end
            prev_v  <= tx_valid;
            prev_d  <= tx_data;
            prev_hs <= tx_valid && tx_ready;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (rand_rdy) tx_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic put_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        last_t   = cyc;
        step();
        rx_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 300) begin
            step();
            n++;
        end
        chk("reply_done", busy, 0);
    endtask

    function automatic job_t rand_job();
        job_t j;
        j.di  = {$urandom(), $urandom(), $urandom(), $urandom(),
                 $urandom(), $urandom(), $urandom(), $urandom()};
        j.dg  = {$urandom(), $urandom(), $urandom(), $urandom(),
                 $urandom(), $urandom(), $urandom(), $urandom()};
        j.mk  = $urandom();
        j.tm  = $urandom();
        j.tg  = $urandom();
        j.nc  = $urandom();
        j.cnt = 8'd0;
        return j;
    endfunction

    // Big-endian serialisation in field order.
    task automatic build(input job_t j);
        for (int i = 0; i < 32; i++) begin
            fb[i]      = j.di[255-8*i -: 8];
            fb[32 + i] = j.dg[255-8*i -: 8];
        end
        for (int i = 0; i < 4; i++) begin
            fb[64 + i] = j.mk[31-8*i -: 8];
            fb[68 + i] = j.tm[31-8*i -: 8];
            fb[72 + i] = j.tg[31-8*i -: 8];
            fb[76 + i] = j.nc[31-8*i -: 8];
        end
    endtask

    task automatic send_job(input job_t j, input logic [7:0] ckx,
                            input int gap_max, input bit wait_rep);
        logic [7:0] ck = 8'h00;
        build(j);
        for (int i = 0; i < 80; i++) ck ^= fb[i];
        if (ckx == 8'h00) begin
            model_cnt = model_cnt + 8'd1;
            j.cnt     = model_cnt;
            last_good = j;
            exp_job.push_back(j);
            exp_tx.push_back(8'h06);
        end else begin
            exp_ej.push_back(last_good);
            exp_ec.push_back(-1);
            exp_tx.push_back(8'h15);
        end
        put_byte(8'hA5);
        for (int i = 0; i < 80; i++) begin
            put_byte(fb[i]);
            if (gap_max > 0) repeat ($urandom_range(0, gap_max)) step();
        end
        put_byte(ck ^ ckx);
        if (wait_rep) wait_idle();
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, ".di"}, digest_initial, 0);
        chk({nm, ".dg"}, digest, 0);
        chk({nm, ".fields"}, {merkle, time_out, target, nonce}, 0);
        chk({nm, ".pulses"}, {write_en, frame_err, busy, tx_valid}, 0);
        chk({nm, ".tx_data"}, tx_data, 0);
        chk({nm, ".good_cnt"}, good_cnt, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        job_t j;
        job_t j1;
        int   n;
        rst_n     = 1'b0;
        rx_data   = 8'h00;
        rx_valid  = 1'b0;
        tx_ready  = 1'b1;
        rand_rdy  = 1'b0;
        last_good = '0;
        model_cnt = 8'd0;
        last_t    = 0;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        #2 rst_n = 1'b1;
        step();

        // Known good frame, back-to-back bytes.
        j1.di  = 256'hF59007B5_0A1B2C3D_4E5F6071_8293A4B5_C6D7E8F9_11223344_55667788_3BC75771;
        j1.dg  = 256'hF7A528B9_99AABBCC_DDEEFF00_12345678_9ABCDEF0_0F1E2D3C_4B5A6978_FA09E776;
        j1.mk  = 32'h252db801;
        j1.tm  = 32'h130dae51;
        j1.tg  = 32'h6461011a;
        j1.nc  = 32'h3aeb9bb0;
        j1.cnt = 8'd0;
        send_job(j1, 8'h00, 0, 1);
        chk("t1_good_cnt", good_cnt, 1);
        chk("t1_nonce", nonce, 32'h3aeb9bb0);

        // Same frame with the checksum flipped.
        send_job(j1, 8'h01, 0, 1);
        chk("t2_good_cnt", good_cnt, 1);
        chk("t2_digest", digest, j1.dg);

        // Leading garbage and sync value as payload byte 0.
        put_byte(8'h00);
        put_byte(8'hFF);
        put_byte(8'h12);
        j = rand_job();
        j.di[255:248] = 8'hA5;
        send_job(j, 8'h00, 0, 1);
        chk("t3_di_top", digest_initial[255:248], 8'hA5);

        // Timeout after sync plus 10 bytes.
        put_byte(8'hA5);
        for (int i = 0; i < 10; i++) put_byte(8'($urandom()));
        exp_ej.push_back(last_good);
        exp_ec.push_back(last_t + 1 + TO);
        repeat (TO + 10) step();
        chk("t4_busy", busy, 0);
        send_job(rand_job(), 8'h00, 0, 1);

        // Reply backpressure with bytes dropped meanwhile.
        tx_ready = 1'b0;
        send_job(rand_job(), 8'h00, 0, 0);
        put_byte(8'hA5);
        for (int i = 0; i < 19; i++) put_byte(8'($urandom()));
        chk("t5_tx_valid_held", tx_valid, 1);
        tx_ready = 1'b1;
        step();
        chk("t5_busy_after", busy, 0);
        chk("t5_tx_valid_after", tx_valid, 0);
        send_job(rand_job(), 8'h00, 0, 1);

        // Randomised frames, gaps, garbage and checksum errors.
        rand_rdy = 1'b1;
        for (int f = 0; f < 40; f++) begin
            repeat ($urandom_range(0, 3)) begin
                logic [7:0] g;
                g = 8'($urandom());
                if (g == 8'hA5) g = 8'h00;
                put_byte(g);
            end
            send_job(rand_job(),
                     ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00,
                     2, 1);
        end
        rand_rdy = 1'b0;
        tx_ready = 1'b1;

        // Drive the accepted-job total to 256 so the counter wraps to 0.
        n = 256 - int'(model_cnt);
        for (int f = 0; f < n; f++) send_job(rand_job(), 8'h00, 0, 1);
        chk("t7_wrap", good_cnt, 0);

        // Reset at payload byte 40.
        put_byte(8'hA5);
        for (int i = 0; i < 40; i++) put_byte(8'($urandom()));
        #2 rst_n = 1'b0;
        #1 chk_zero("mid_frame_reset");
        last_good = '0;
        model_cnt = 8'd0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        step();
        send_job(rand_job(), 8'h00, 0, 1);
        chk("t8_good_cnt", good_cnt, 1);

        // Reset while a reply is pending.
        tx_ready = 1'b0;
        send_job(rand_job(), 8'h00, 0, 0);
        step();
        chk("t9_tx_pending", tx_valid, 1);
        #2 rst_n = 1'b0;
        #1 chk("t9_tx_drop", tx_valid, 0);
        exp_tx.delete();
        last_good = '0;
        model_cnt = 8'd0;
        tx_ready  = 1'b1;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        step();
        send_job(rand_job(), 8'h00, 0, 1);

        repeat (5) step();
        chk("left_jobs", exp_job.size(), 0);
        chk("left_replies", exp_tx.size(), 0);
        chk("left_errs", exp_ej.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
